// File: rtl/min_sum_check_node_stream.sv
// Min-sum check-node row processor.
// Streams one sign-magnitude variable-to-check message per accepted cycle.
// At the end of a row it reports min1, min2, the arrival index of min1 and
// the XOR of all sign bits. An optional offset is subtracted from both
// minima, saturating at zero.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; results from the last row are held
// LOAD   | accepting row_deg messages, in_ready/busy high
// FIN    | one cycle with done high; a new start here is taken without
//        | a bubble so rows can run back to back
module min_sum_check_node_stream #(
    parameter int W       = 32,
    parameter int MAX_DEG = 40,
    parameter int DEG_W   = 6,
    parameter int OFFSET  = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [DEG_W-1:0] i_row_deg,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [W-1:0]     i_in_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [W-2:0]     o_min1,
    output logic [W-2:0]     o_min2,
    output logic [DEG_W-1:0] o_min1_pos,
    output logic             o_sign_prod,
    output logic             o_deg_err
);

    localparam logic [W-2:0]     LP_OFF = (W-1)'(OFFSET);
    localparam logic [DEG_W-1:0] LP_MAX = DEG_W'(MAX_DEG);
    localparam logic [DEG_W-1:0] LP_MIN = DEG_W'(2);
    localparam logic [DEG_W-1:0] LP_ONE = DEG_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DEG_W-1:0] r_count;
    logic [DEG_W-1:0] r_deg;
    logic [W-2:0]     r_m1;
    logic [W-2:0]     r_m2;
    logic [DEG_W-1:0] r_pos;
    logic             r_sign;

    logic [W-2:0]     r_min1;
    logic [W-2:0]     r_min2;
    logic [DEG_W-1:0] r_min1_pos;
    logic             r_sign_prod;
    logic             r_deg_err;
    logic             r_done;

    logic             w_start_samp;
    logic             w_deg_ok;
    logic             w_accept;
    logic             w_last;
    logic [W-2:0]     w_mag;
    logic             w_lt1;
    logic             w_lt2;
    logic [W-2:0]     w_m1_nxt;
    logic [W-2:0]     w_m2_nxt;
    logic [DEG_W-1:0] w_pos_nxt;
    logic             w_sign_nxt;

    // Saturating offset-min-sum correction.
    function automatic logic [W-2:0] f_offset(input logic [W-2:0] m);
        return (m > LP_OFF) ? (m - LP_OFF) : '0;
    endfunction

    // Start is honoured in IDLE and in FIN (back-to-back rows), never in LOAD.
    assign w_start_samp = i_start && (r_state != S_LOAD);
    assign w_deg_ok     = (i_row_deg >= LP_MIN) && (i_row_deg <= LP_MAX);
    assign w_accept     = (r_state == S_LOAD) && i_in_valid;
    assign w_last       = w_accept && (r_count == (r_deg - LP_ONE));

    // Running min1/min2 update; strict less-than keeps the earliest index on ties.
    always_comb begin
        w_mag      = i_in_data[W-2:0];
        w_lt1      = w_mag < r_m1;
        w_lt2      = w_mag < r_m2;
        w_m1_nxt   = w_lt1 ? w_mag : r_m1;
        w_m2_nxt   = w_lt1 ? r_m1 : (w_lt2 ? w_mag : r_m2);
        w_pos_nxt  = w_lt1 ? r_count : r_pos;
        w_sign_nxt = r_sign ^ i_in_data[W-1];
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start && w_deg_ok) w_state_nxt = S_LOAD;
            S_LOAD: if (w_last) w_state_nxt = S_FIN;
            S_FIN:  w_state_nxt = (i_start && w_deg_ok) ? S_LOAD : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        o_in_ready = 1'b0;
        o_busy     = 1'b0;
        if (r_state == S_LOAD) begin
            o_in_ready = 1'b1;
            o_busy     = 1'b1;
        end
    end

    // Row accumulator and registered results.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count     <= '0;
            r_deg       <= '0;
            r_m1        <= '1;
            r_m2        <= '1;
            r_pos       <= '0;
            r_sign      <= 1'b0;
            r_min1      <= '0;
            r_min2      <= '0;
            r_min1_pos  <= '0;
            r_sign_prod <= 1'b0;
            r_deg_err   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_samp) begin
                if (w_deg_ok) begin
                    r_deg     <= i_row_deg;
                    r_count   <= '0;
                    r_m1      <= '1;
                    r_m2      <= '1;
                    r_pos     <= '0;
                    r_sign    <= 1'b0;
                    r_deg_err <= 1'b0;
                end else begin
                    // Illegal degree: report an empty, flagged result.
                    r_deg_err   <= 1'b1;
                    r_done      <= 1'b1;
                    r_min1      <= '0;
                    r_min2      <= '0;
                    r_min1_pos  <= '0;
                    r_sign_prod <= 1'b0;
                end
            end else if (w_accept) begin
                r_m1    <= w_m1_nxt;
                r_m2    <= w_m2_nxt;
                r_pos   <= w_pos_nxt;
                r_sign  <= w_sign_nxt;
                r_count <= r_count + LP_ONE;
                if (w_last) begin
                    // Results include the final message, so they are taken
                    // from the update path rather than the accumulators.
                    r_min1      <= f_offset(w_m1_nxt);
                    r_min2      <= f_offset(w_m2_nxt);
                    r_min1_pos  <= w_pos_nxt;
                    r_sign_prod <= w_sign_nxt;
                    r_done      <= 1'b1;
                end
            end
        end
    end

    assign o_done      = r_done;
    assign o_min1      = r_min1;
    assign o_min2      = r_min2;
    assign o_min1_pos  = r_min1_pos;
    assign o_sign_prod = r_sign_prod;
    assign o_deg_err   = r_deg_err;

endmodule

// File: tb/tb_min_sum_check_node_stream.sv
// Directed bench for min_sum_check_node_stream. Two instances share the
// stimulus: one plain min-sum, one with OFFSET=2. Expected results are
// queued when a row is driven and compared when done pulses.
module tb_min_sum_check_node_stream;

    localparam int W = 32;
    localparam int DW = 6;

    typedef struct {
        logic [W-2:0]  m1;
        logic [W-2:0]  m2;
        logic [W-2:0]  m1o;
        logic [W-2:0]  m2o;
        logic [DW-1:0] pos;
        logic          sgn;
        logic          derr;
    } exp_t;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic [DW-1:0] i_row_deg;
    logic          i_in_valid;
    logic [W-1:0]  i_in_data;

    logic          o_in_ready, o_busy, o_done, o_sign_prod, o_deg_err;
    logic [W-2:0]  o_min1, o_min2;
    logic [DW-1:0] o_min1_pos;
    logic          o2_in_ready, o2_busy, o2_done, o2_sign_prod, o2_deg_err;
    logic [W-2:0]  o2_min1, o2_min2;
    logic [DW-1:0] o2_min1_pos;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   done_q[$];
    exp_t prev;
    logic [W-1:0] stim[64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    min_sum_check_node_stream #(.W(W), .MAX_DEG(40), .DEG_W(DW), .OFFSET(0)) u_dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_row_deg(i_row_deg),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_busy(o_busy), .o_done(o_done), .o_min1(o_min1), .o_min2(o_min2),
        .o_min1_pos(o_min1_pos), .o_sign_prod(o_sign_prod), .o_deg_err(o_deg_err)
    );

    min_sum_check_node_stream #(.W(W), .MAX_DEG(40), .DEG_W(DW), .OFFSET(2)) u_dut_off (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_row_deg(i_row_deg),
        .i_in_valid(i_in_valid), .o_in_ready(o2_in_ready), .i_in_data(i_in_data),
        .o_busy(o2_busy), .o_done(o2_done), .o_min1(o2_min1), .o_min2(o2_min2),
        .o_min1_pos(o2_min1_pos), .o_sign_prod(o2_sign_prod), .o_deg_err(o2_deg_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-2:0] sat2(input logic [W-2:0] m);
        return (m > 31'd2) ? m - 31'd2 : '0;
    endfunction

    // Reference: scan stim[0..deg-1] in arrival order.
    function automatic exp_t model(input int deg);
        exp_t e;
        e.m1 = '1; e.m2 = '1; e.pos = '0; e.sgn = 1'b0; e.derr = 1'b0;
        for (int k = 0; k < deg; k++) begin
            if (stim[k][W-2:0] < e.m1) begin
                e.m2 = e.m1; e.m1 = stim[k][W-2:0]; e.pos = DW'(k);
            end else if (stim[k][W-2:0] < e.m2) begin
                e.m2 = stim[k][W-2:0];
            end
            e.sgn ^= stim[k][W-1];
        end
        e.m1o = sat2(e.m1);
        e.m2o = sat2(e.m2);
        return e;
    endfunction

    function automatic exp_t zero_exp(input logic derr);
        exp_t e;
        e.m1 = '0; e.m2 = '0; e.m1o = '0; e.m2o = '0; e.pos = '0; e.sgn = 1'b0; e.derr = derr;
        return e;
    endfunction

    task automatic set_stim(input int idx, input int mag, input logic s);
        stim[idx] = {s, 31'(mag)};
    endtask

    // Drive one legal row. Ends #1 after the edge that took the last input,
    // so a following call asserts start in the done cycle.
    task automatic run_row(input int deg, input bit gap, input bit hold);
        exp_t e;
        e = model(deg);
        @(negedge clk);
        i_start = 1'b1; i_row_deg = DW'(deg); i_in_valid = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        chk("busy_after_start", {o_busy, o_in_ready}, 2'b11);
        chk("held_min1", o_min1, prev.m1);
        chk("held_pos_sign", {o_min1_pos, o_sign_prod}, {prev.pos, prev.sgn});
        chk("deg_err_cleared", o_deg_err, 1'b0);
        for (int i = 0; i < deg; i++) begin
            i_start = hold;
            if (hold) i_row_deg = DW'(1);
            if (gap && i > 0) begin
                i_in_valid = 1'b0;
                @(negedge clk);
                chk("gap_no_done", o_done, 1'b0);
            end
            i_in_valid = 1'b1;
            i_in_data  = stim[i];
            if (i < deg - 1) @(negedge clk);
        end
        @(posedge clk);
        #1;
        done_q.push_back(cyc);
        i_in_valid = 1'b0;
        i_start = 1'b0;
        prev = e;
    endtask

    task automatic run_bad(input int deg);
        exp_t e;
        e = zero_exp(1'b1);
        @(negedge clk);
        i_start = 1'b1; i_row_deg = DW'(deg); i_in_valid = 1'b1; i_in_data = '0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        done_q.push_back(cyc);
        i_start = 1'b0; i_in_valid = 1'b0;
        @(negedge clk);
        chk("bad_deg_no_load", {o_busy, o_in_ready, o_deg_err}, 3'b001);
        prev = e;
    endtask

    // Scoreboard monitor: compare on every done pulse.
    initial begin
        exp_t e;
        int   dc;
        forever begin
            @(negedge clk);
            if (o_done === 1'b1 || o2_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", o_done, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    dc = (done_q.size() != 0) ? done_q.pop_front() : -1;
                    chk("done_cycle", 64'(cyc), 64'(dc));
                    chk("done_both", {o_done, o2_done}, 2'b11);
                    chk("min1", o_min1, e.m1);
                    chk("min2", o_min2, e.m2);
                    chk("min1_pos", o_min1_pos, e.pos);
                    chk("sign_prod", o_sign_prod, e.sgn);
                    chk("deg_err", o_deg_err, e.derr);
                    chk("off_min1", o2_min1, e.m1o);
                    chk("off_min2", o2_min2, e.m2o);
                    chk("off_pos_sign", {o2_min1_pos, o2_sign_prod}, {e.pos, e.sgn});
                end
            end
        end
    end

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_row_deg = '0; i_in_valid = 1'b0; i_in_data = '0;
        prev = zero_exp(1'b0);
        repeat (3) @(negedge clk);
        chk("rst_outputs", {o_done, o_min1, o_min2, o_min1_pos, o_sign_prod, o_deg_err}, 64'd0);
        chk("rst_handshake", {o_busy, o_in_ready}, 2'b00);
        i_reset = 1'b0;
        @(negedge clk);
        i_in_valid = 1'b1;
        @(negedge clk);
        chk("idle_ignores_valid", {o_busy, o_in_ready, o_done}, 3'b000);
        i_in_valid = 1'b0;

        // 40-degree row, magnitudes descending, alternating signs.
        for (int i = 0; i < 40; i++) set_stim(i, 40 - i, i[0]);
        run_row(40, 1'b0, 1'b0);

        // Ties and gapped valid, back to back with the previous row.
        set_stim(0, 7, 0); set_stim(1, 3, 1); set_stim(2, 9, 1);
        set_stim(3, 3, 0); set_stim(4, 5, 0); set_stim(5, 8, 1);
        run_row(6, 1'b1, 1'b0);

        // Illegal degrees on both sides of the legal range.
        run_bad(1);
        run_bad(41);

        // Offset saturation row.
        set_stim(0, 1, 1); set_stim(1, 5, 1); set_stim(2, 2, 1); set_stim(3, 6, 0);
        run_row(4, 1'b0, 1'b0);

        // All-ones magnitudes.
        for (int i = 0; i < 3; i++) set_stim(i, 32'h7FFF_FFFF, 1'b0);
        run_row(3, 1'b0, 1'b0);

        // Reset in the middle of a 40-degree row.
        for (int i = 0; i < 40; i++) set_stim(i, 100 + i, 1'b1);
        @(negedge clk);
        i_start = 1'b1; i_row_deg = DW'(40);
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_in_valid = 1'b1; i_in_data = stim[i];
            @(negedge clk);
        end
        i_in_valid = 1'b0;
        #1 i_reset = 1'b1;
        #1;
        chk("async_rst_results", {o_min1, o_min2, o_min1_pos, o_sign_prod, o_deg_err}, 64'd0);
        chk("async_rst_ctrl", {o_busy, o_in_ready, o_done, o2_busy}, 4'b0000);
        @(negedge clk);
        i_reset = 1'b0;
        prev = zero_exp(1'b0);

        // Fresh row after the abort.
        set_stim(0, 9, 1); set_stim(1, 4, 0); set_stim(2, 4, 0); set_stim(3, 2, 1); set_stim(4, 7, 1);
        run_row(5, 1'b0, 1'b0);

        // Start held through LOAD (with an illegal degree), then a new row
        // started in the done cycle.
        set_stim(0, 6, 0); set_stim(1, 2, 0); set_stim(2, 8, 1);
        run_row(3, 1'b0, 1'b1);
        set_stim(0, 5, 0); set_stim(1, 5, 0); set_stim(2, 1, 0); set_stim(3, 3, 0);
        run_row(4, 1'b0, 1'b0);

        // Let the last result drain, bounded.
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
